// File: rtl/sram_responder_pkg.sv
// Shared encodings and constants for the SRAM pin-bus responder.
package sram_responder_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ECLS_NONE  = 2'd0,
    ECLS_READ  = 2'd1,
    ECLS_WRITE = 2'd2
  } edge_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// LAT-deep {valid, data} shift register carrying read beats to the bus.
module sram_read_pipe
  import sram_responder_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_beat_t push,
  output rd_beat_t head
);

  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0][DATA_W-1:0] data_pipe;

  if (LAT == 1) begin : g_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe  <= '0;
        data_pipe <= '0;
      end else begin
        vld_pipe  <= push.vld;
        data_pipe <= push.data;
      end
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe  <= '0;
        data_pipe <= '0;
      end else begin
        vld_pipe  <= {vld_pipe[LAT-2:0], push.vld};
        data_pipe <= {data_pipe[LAT-2:0], push.data};
      end
    end
  end

  assign head.vld  = vld_pipe[LAT-1];
  assign head.data = data_pipe[LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Device-side 16-bit SRAM model: byte-masked writes, pipelined reads onto
// the shared DQ bus, backdoor peek, access counters and out-of-range flag.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 18,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_W-1:0]     SRAM_DQ,
  input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  input  logic                  SRAM_WE_N,
  input  logic                  SRAM_UB_N,
  input  logic                  SRAM_LB_N,
  input  logic                  SRAM_CE_N,
  input  logic                  SRAM_OE_N,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count,
  output logic                  oob_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Full-width bound so high address bits take part in the range check.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  edge_cls_e   ecls;
  bus_state_e  state;
  logic [ADDR_WIDTH-1:0] last_rd_addr;
  logic        addr_ok;
  logic [IDX_W-1:0] idx;
  rd_beat_t    rd_push, rd_head;
  logic        drive_en;

  assign addr_ok = in_range(SRAM_ADDR);
  assign idx     = SRAM_ADDR[IDX_W-1:0];

  always_comb begin
    ecls = ECLS_NONE;
    if (!SRAM_CE_N) ecls = SRAM_WE_N ? ECLS_READ : ECLS_WRITE;
  end

  always_ff @(posedge clk) begin
    if (ecls == ECLS_WRITE && addr_ok) begin
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Array is sampled at the read edge, so later writes never reach in-flight beats.
  always_comb begin
    rd_push.vld  = (ecls == ECLS_READ);
    rd_push.data = '0;
    if (ecls == ECLS_READ && addr_ok) rd_push.data = mem[idx];
  end

  sram_read_pipe #(.LAT(READ_LATENCY)) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (rd_push),
    .head (rd_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_rd_addr <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      oob_err      <= 1'b0;
    end else begin
      unique case (ecls)
        ECLS_WRITE: begin
          state    <= ST_WRITE;
          wr_count <= sat_inc(wr_count);
          if (!addr_ok) oob_err <= 1'b1;
        end
        ECLS_READ: begin
          state        <= ST_READ;
          last_rd_addr <= SRAM_ADDR;
          // Address and read beats of one controller access count once.
          if (state != ST_READ || SRAM_ADDR != last_rd_addr)
            rd_count <= sat_inc(rd_count);
          if (!addr_ok) oob_err <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_data = in_range(dbg_addr) ? mem[dbg_addr[IDX_W-1:0]] : '0;

  // Live-pin gating keeps the bus released the moment the controller drops WE_N.
  assign drive_en = rd_head.vld && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[15:8] = (drive_en && !SRAM_UB_N) ? rd_head.data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_en && !SRAM_LB_N) ? rd_head.data[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized and directed bench for sram_responder at read latencies 1 and 3.
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1, ub_n = 1'b1, lb_n = 1'b1;
  logic [17:0] addr = '0, dbg_a = '0;
  logic [15:0] tb_dq = '0;
  logic        tb_dq_en = 1'b0;

  wire  [15:0] dq1, dq3;
  logic [15:0] dbg1, dbg3, rd1, rd3, wr1, wr3;
  logic        oob1, oob3;

  assign dq1 = tb_dq_en ? tb_dq : 16'hzzzz;
  assign dq3 = tb_dq_en ? tb_dq : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq1[i]);
    pullup (dq3[i]);
  end

  sram_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .dbg_addr(dbg_a), .dbg_data(dbg1), .rd_count(rd1), .wr_count(wr1), .oob_err(oob1)
  );

  sram_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .dbg_addr(dbg_a), .dbg_data(dbg3), .rd_count(rd3), .wr_count(wr3), .oob_err(oob3)
  );

  // Reference model: word array, counters and a history of what each edge read.
  logic [15:0] mem_m [1024];
  logic [15:0] rd_m, wr_m;
  logic        oob_m;
  int          prev_cls;          // 0 none, 1 read, 2 write
  logic [17:0] last_rd;
  logic [16:0] hist [$];          // {valid, data} per edge, newest last
  logic [17:0] in_set [18];
  logic [17:0] oob_set [4];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    rd_m = '0; wr_m = '0; oob_m = 1'b0; prev_cls = 0; last_rd = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [15:0] rdat;
    int cls;
    if (!rst) return;
    if (ce_n) begin
      cls = 0;
      hist.push_back(17'h0);
    end else if (!we_n) begin
      cls = 2;
      if (addr < 18'd1024) begin
        if (!lb_n) mem_m[addr[9:0]][7:0]  = tb_dq[7:0];
        if (!ub_n) mem_m[addr[9:0]][15:8] = tb_dq[15:8];
      end else oob_m = 1'b1;
      wr_m = sat(wr_m);
      hist.push_back(17'h0);
    end else begin
      cls = 1;
      rdat = (addr < 18'd1024) ? mem_m[addr[9:0]] : 16'h0000;
      if (addr >= 18'd1024) oob_m = 1'b1;
      if (prev_cls != 1 || addr != last_rd) rd_m = sat(rd_m);
      last_rd = addr;
      hist.push_back({1'b1, rdat});
    end
    prev_cls = cls;
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  function automatic logic [15:0] exp_bus(input int lat);
    logic [16:0] h;
    logic [15:0] b;
    b = tb_dq_en ? tb_dq : 16'hFFFF;
    h = (hist.size() >= lat) ? hist[hist.size() - lat] : 17'h0;
    if (h[16] && !ce_n && !oe_n && we_n) begin
      if (!ub_n) b[15:8] = h[15:8];
      if (!lb_n) b[7:0]  = h[7:0];
    end
    return b;
  endfunction

  task automatic check_all();
    logic [15:0] d;
    d = (dbg_a < 18'd1024) ? mem_m[dbg_a[9:0]] : 16'h0000;
    chk("dq_l1", dq1, exp_bus(1));
    chk("dq_l3", dq3, exp_bus(3));
    chk("dbg_l1", dbg1, d);
    chk("dbg_l3", dbg3, d);
    chk("rdcnt_l1", rd1, rd_m);
    chk("rdcnt_l3", rd3, rd_m);
    chk("wrcnt_l1", wr1, wr_m);
    chk("wrcnt_l3", wr3, wr_m);
    chk("oob_l1", 16'(oob1), 16'(oob_m));
    chk("oob_l3", 16'(oob3), 16'(oob_m));
  endtask

  task automatic set_pins(input logic ce, input logic we, input logic oe, input logic ub,
                          input logic lb, input logic [17:0] a, input logic [15:0] d);
    ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb;
    addr = a; dbg_a = a; tb_dq = d;
    tb_dq_en = !ce && !we;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    set_pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, d);
    tick();
  endtask

  task automatic rd(input logic [17:0] a);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0);
    tick();
  endtask

  task automatic do_reset();
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd1024, 16'h0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [17:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return oob_set[$urandom_range(0, 3)];
    return in_set[$urandom_range(0, 17)];
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) in_set[i] = 18'(i);
    in_set[16] = 18'd1022; in_set[17] = 18'd1023;
    oob_set[0] = 18'd1024; oob_set[1] = 18'd1029;
    oob_set[2] = 18'h10005; oob_set[3] = 18'h3FFFF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Give every in-range test location known contents.
    for (int i = 0; i < 18; i++) wr(in_set[i], 16'($urandom));
    do_reset();
    check_all();
    chk("rst_dq", dq1, 16'hFFFF);
    chk("rst_wr", wr1, 16'h0);
    chk("rst_oob", 16'(oob1), 16'h0);

    // Write then read, latency 1.
    wr(18'd5, 16'h1234);
    rd(18'd5);
    chk("wr_rd_dq", dq1, 16'h1234);
    chk("wr_rd_dbg", dbg1, 16'h1234);
    chk("wr_rd_wrc", wr1, 16'd1);
    chk("wr_rd_rdc", rd1, 16'd1);

    // Byte lanes.
    wr(18'd7, 16'h1234);
    set_pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'd7, 16'hABCD);
    tick();
    chk("lane_dbg", dbg1, 16'h12CD);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 18'd7, 16'h0);
    tick();
    chk("lane_dq", dq1, 16'h12FF);

    // Controller-style 32-bit store and two-beat reads.
    do_reset();
    wr(18'd0, 16'hBEEF);
    wr(18'd1, 16'hDEAD);
    rd(18'd0);
    rd(18'd0);
    chk("ctl_rd0", dq1, 16'hBEEF);
    rd(18'd1);
    rd(18'd1);
    chk("ctl_rd1", dq1, 16'hDEAD);
    chk("ctl_rdc", rd1, 16'd2);
    chk("ctl_wrc", wr1, 16'd2);

    // Out of range.
    wr(18'd1024, 16'hFFFF);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd1024, 16'h0);
    dbg_a = 18'd0;
    tick();
    chk("oob_dq", dq1, 16'h0000);
    chk("oob_flag", 16'(oob1), 16'h1);
    chk("oob_mem0", dbg1, 16'hBEEF);
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0);
    tick();
    chk("oob_sticky", 16'(oob1), 16'h1);

    // Latency 3: read, overwrite, then observe the old data and the WE_N release.
    rd(18'd5);
    wr(18'd5, 16'h5555);
    rd(18'd6);
    we_n = 1'b0;
    #1;
    check_all();
    chk("lat_hiz", dq3, 16'hFFFF);
    we_n = 1'b1;
    #1;
    check_all();
    chk("lat_old", dq3, 16'h1234);
    tick();

    // Asynchronous reset while the bus is driven.
    rd(18'd5);
    chk("pre_rst_dq", dq1, 16'h5555);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_dq", dq1, 16'hFFFF);
    chk("arst_rdc", rd1, 16'h0);
    chk("arst_oob", 16'(oob1), 16'h0);
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd5, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd(18'd5);
    chk("post_rst_dq", dq1, 16'h5555);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [17:0] a;
      a = ($urandom_range(0, 2) == 0) ? addr : pick_addr();
      set_pins(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), a, 16'($urandom));
      if ($urandom_range(0, 1) == 0) dbg_a = pick_addr();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable device-side model of the 16-bit asynchronous-style SRAM. It sits on the far side of the SRAM pin bus driven by the memory-stage SRAM controller.
- Decodes the SRAM_* strobes, stores write data with per-byte lane masking, and returns read data through a configurable-latency pipeline on the shared bidirectional SRAM_DQ.
- Provides a backdoor peek port, access counters and an out-of-range flag. These support verification and on-board debug of the controller without the physical chip.

Parameters:
ADDR_WIDTH, 18, width of SRAM_ADDR and dbg_addr
MEM_DEPTH, 1024, number of 16-bit words implemented (locations 0..MEM_DEPTH-1)
READ_LATENCY, 1, clock edges from read-address sampling to read data on SRAM_DQ; legal range 1..4

Ports:
clk  input  1  single clock; all sampling on rising edge
rst  input  1  reset, asynchronous, active-low
SRAM_DQ  inout  16  data bus; driven by this block only during read beats, else high-Z
SRAM_ADDR  input  ADDR_WIDTH  word address
SRAM_WE_N  input  1  write enable, active-low
SRAM_UB_N  input  1  upper byte lane [15:8] enable, active-low
SRAM_LB_N  input  1  lower byte lane [7:0] enable, active-low
SRAM_CE_N  input  1  chip enable, active-low
SRAM_OE_N  input  1  output enable, active-low
dbg_addr  input  ADDR_WIDTH  backdoor read address
dbg_data  output  16  combinational mem[dbg_addr]; 16'h0000 if out of range
rd_count  output  16  read accesses, saturating
wr_count  output  16  write beats, saturating
oob_err  output  1  sticky: an access hit an address >= MEM_DEPTH

Behaviour:
- Reset (rst=0, async):
  - Read pipeline valid bits, rd_count, wr_count and oob_err clear to 0; the read data register clears to 16'h0000.
  - Bus FSM goes to IDLE and SRAM_DQ releases to high-Z immediately, without waiting for a clock edge.
  - Memory contents are not reset.
- Edge classification on each rising clk, using the pin values sampled at that edge:
  - SRAM_CE_N=1 -> NONE.
  - SRAM_CE_N=0 and SRAM_WE_N=0 -> WRITE.
  - SRAM_CE_N=0 and SRAM_WE_N=1 -> READ.
- WRITE:
  - If SRAM_ADDR < MEM_DEPTH: mem[addr][7:0] <= SRAM_DQ[7:0] when LB_N=0; mem[addr][15:8] <= SRAM_DQ[15:8] when UB_N=0. Lanes with their enable high are unchanged.
  - If SRAM_ADDR >= MEM_DEPTH: the write is ignored and oob_err <= 1.
  - wr_count increments on every WRITE edge. A 32-bit controller store therefore counts 2.
- READ:
  - The array is read at the sampling edge (value before any later write) and pushed into a READ_LATENCY-deep pipeline of {valid, data}.
  - Out-of-range reads push 16'h0000 and set oob_err.
  - Result is registered: with READ_LATENCY=1, data for an address sampled at edge N is on SRAM_DQ in cycle N..N+1. This matches the controller's address-beat/read-beat pair.
- DQ drive: the block drives SRAM_DQ = pipeline head data only when all of the following hold:
  - head valid=1;
  - current SRAM_CE_N=0, SRAM_OE_N=0 and SRAM_WE_N=1 (combinational gating on live pins, so there is no contention the cycle the controller asserts WE_N).
  - Per-lane gating: [15:8] is high-Z when UB_N=1, and [7:0] is high-Z when LB_N=1.
- Bus FSM (IDLE, READ, WRITE) holds the class of the last edge; NONE maps to IDLE.
  - rd_count increments on a READ edge when the FSM is not in READ, or when SRAM_ADDR differs from the previously sampled read address.
  - This means the controller's repeated address across ADDR/READ beats counts once.
- Counters saturate at 16'hFFFF.
- Write and read at the same edge are impossible by classification.
- A write to an address with a read in flight does not alter the in-flight data.
- SRAM_ADDR bits above those needed for MEM_DEPTH participate in the out-of-range check and are not aliased.

Decomposition:
- Shared package holds:
  - edge class encodings NONE/READ/WRITE;
  - FSM state encodings IDLE/READ/WRITE;
  - width constant 16 for data, 16 for counters.
- One sub-module is natural: sram_read_pipe, a parameterized READ_LATENCY-deep {valid, data} shift register with async active-low clear.
- Storage array, write masking, DQ tristate and counters stay in the top level.

Test Plan:
- Write/read, READ_LATENCY=1:
  - Stimulus: edge WRITE addr 5 DQ=16'h1234 (UB_N=LB_N=0); then READ addr 5.
  - Required response: SRAM_DQ=16'h1234 in the following cycle; dbg_addr=5 gives 16'h1234; wr_count=1, rd_count=1.
- Byte lanes:
  - Stimulus: mem[7]=16'h1234 preloaded by write; then WRITE addr 7 DQ=16'hABCD with UB_N=1, LB_N=0.
  - Required response: dbg_data=16'h12CD. A read with LB_N=1 drives DQ[15:8]=8'h12 and DQ[7:0]=high-Z.
- Controller sequence:
  - Stimulus: write halves 16'hBEEF at addr 0 and 16'hDEAD at addr 1, then read addr 0 (2 beats) and addr 1 (2 beats).
  - Required response: read beats return 16'hBEEF then 16'hDEAD; rd_count=2, wr_count=2.
- Out of range, MEM_DEPTH=1024:
  - Stimulus: WRITE addr 1024 DQ=16'hFFFF; then READ addr 1024.
  - Required response: oob_err=1 and stays 1; DQ returns 16'h0000; mem[0] unchanged.
- Latency and contention, READ_LATENCY=3:
  - Stimulus: READ addr 5 at edge N, then WRITE addr 5 DQ=16'h5555 at edge N+1.
  - Required response: DQ is high-Z while WE_N=0. Data returned in cycle N+3 is the old 16'h1234.
- Reset mid-read:
  - Stimulus: rst=0 asserted asynchronously while DQ is driven.
  - Required response: DQ goes high-Z before the next edge; counters=0, oob_err=0. After release, a read of addr 5 still returns the preserved contents.
